// File: rtl/inv_sbox_serial.sv
// Serial AES InvSubBytes over a 128-bit state, LANES bytes per step, using GF((2^4)^2) inversion.
// Define INV_SBOX_PIPE_EN to register between the GF(2^4) inversion and the output multiply.
module inv_sbox_serial #(
  parameter int unsigned LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int unsigned   STEPS     = 16 / LANES;
  localparam int unsigned   CW        = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
`ifdef INV_SBOX_PIPE_EN
  localparam logic [1:0] S_FLUSH = 2'd2;
`endif
  localparam logic [1:0] S_DONE  = 2'd3;

  // GF(4) = GF(2)[w]/(w^2 + w + 1)
  function automatic logic [1:0] gf4_mul(input logic [1:0] a, input logic [1:0] b);
    return {(a[1] & b[1]) ^ (a[1] & b[0]) ^ (a[0] & b[1]), (a[1] & b[1]) ^ (a[0] & b[0])};
  endfunction

  // GF(16) = GF(4)[y]/(y^2 + y + phi), phi = {10}
  function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
    logic [1:0] hh, hl, lh, ll;
    hh = gf4_mul(a[3:2], b[3:2]);
    hl = gf4_mul(a[3:2], b[1:0]);
    lh = gf4_mul(a[1:0], b[3:2]);
    ll = gf4_mul(a[1:0], b[1:0]);
    return {hh ^ hl ^ lh, gf4_mul(hh, 2'b10) ^ ll};
  endfunction

  function automatic logic [3:0] gf16_sq_lambda(input logic [3:0] x);
    return {x[2] ^ x[1] ^ x[0], x[3] ^ x[0], x[3], x[3] ^ x[2]};
  endfunction

  // x^14 = x^-1, with 0 mapping to 0
  function automatic logic [3:0] gf16_inv(input logic [3:0] x);
    logic [3:0] x2, x4, x8;
    x2 = gf16_mul(x, x);
    x4 = gf16_mul(x2, x2);
    x8 = gf16_mul(x4, x4);
    return gf16_mul(gf16_mul(x8, x4), x2);
  endfunction

  function automatic logic [7:0] iso_map(input logic [7:0] q);
    return {q[7] ^ q[5],
            q[7] ^ q[6] ^ q[4] ^ q[3] ^ q[2] ^ q[1],
            q[7] ^ q[5] ^ q[3] ^ q[2],
            q[7] ^ q[5] ^ q[3] ^ q[2] ^ q[1],
            q[7] ^ q[6] ^ q[2] ^ q[1],
            q[7] ^ q[4] ^ q[3] ^ q[2] ^ q[1],
            q[6] ^ q[4] ^ q[1],
            q[6] ^ q[1] ^ q[0]};
  endfunction

  function automatic logic [7:0] iso_inv(input logic [7:0] q);
    return {q[7] ^ q[6] ^ q[5] ^ q[1],
            q[6] ^ q[2],
            q[6] ^ q[5] ^ q[1],
            q[6] ^ q[5] ^ q[4] ^ q[2] ^ q[1],
            q[5] ^ q[4] ^ q[3] ^ q[2] ^ q[1],
            q[7] ^ q[4] ^ q[3] ^ q[2] ^ q[1],
            q[5] ^ q[4],
            q[6] ^ q[5] ^ q[4] ^ q[2] ^ q[0]};
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] b);
    return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
  endfunction

  // Front half: returns {ah, al, d^-1}
  function automatic logic [11:0] front(input logic [7:0] b);
    logic [7:0] a;
    logic [3:0] d;
    a = iso_map(inv_affine(b));
    d = gf16_sq_lambda(a[7:4]) ^ gf16_mul(a[7:4] ^ a[3:0], a[3:0]);
    return {a[7:4], a[3:0], gf16_inv(d)};
  endfunction

  function automatic logic [7:0] back(input logic [11:0] f);
    return iso_inv({gf16_mul(f[11:8], f[3:0]), gf16_mul(f[11:8] ^ f[7:4], f[3:0])});
  endfunction

  function automatic logic [3:0] byte_idx(input logic [CW-1:0] s, input int j);
    return 4'(int'(s) * int'(LANES) + j);
  endfunction

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] step_q, step_d;
  logic [127:0]  work_q, work_d;
  logic          in_ready_q, out_valid_q, busy_q;
  logic [11:0]   front_c [LANES];

`ifdef INV_SBOX_PIPE_EN
  logic          pv_q, pv_d;
  logic [CW-1:0] pstep_q, pstep_d;
  logic [11:0]   pf_q [LANES];
  logic [11:0]   pf_d [LANES];
`endif

  always_comb begin
    for (int j = 0; j < int'(LANES); j++) begin
      front_c[j] = front(work_q[{byte_idx(step_q, j), 3'b000} +: 8]);
    end
  end

  // Next-state and in-place write-back of the current step
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    work_d  = work_q;
`ifdef INV_SBOX_PIPE_EN
    pv_d    = 1'b0;
    pstep_d = pstep_q;
    pf_d    = pf_q;
    if (pv_q) begin
      for (int j = 0; j < int'(LANES); j++) begin
        work_d[{byte_idx(pstep_q, j), 3'b000} +: 8] = back(pf_q[j]);
      end
    end
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          work_d  = in_data;
          step_d  = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
`ifdef INV_SBOX_PIPE_EN
        pv_d    = 1'b1;
        pstep_d = step_q;
        pf_d    = front_c;
`else
        for (int j = 0; j < int'(LANES); j++) begin
          work_d[{byte_idx(step_q, j), 3'b000} +: 8] = back(front_c[j]);
        end
`endif
        if (step_q == LAST_STEP) begin
`ifdef INV_SBOX_PIPE_EN
          state_d = S_FLUSH;
`else
          state_d = S_DONE;
`endif
        end else begin
          step_d = step_q + CW'(1);
        end
      end
`ifdef INV_SBOX_PIPE_EN
      S_FLUSH: state_d = S_DONE;
`endif
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      step_q      <= '0;
      work_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef INV_SBOX_PIPE_EN
      pv_q        <= 1'b0;
      pstep_q     <= '0;
      for (int j = 0; j < int'(LANES); j++) pf_q[j] <= '0;
`endif
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      work_q      <= work_d;
      in_ready_q  <= (state_d == S_IDLE);
      out_valid_q <= (state_d == S_DONE);
      busy_q      <= (state_d != S_IDLE);
`ifdef INV_SBOX_PIPE_EN
      pv_q        <= pv_d;
      pstep_q     <= pstep_d;
      pf_q        <= pf_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = work_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_inv_sbox_serial.sv
// Directed bench for inv_sbox_serial; golden inverse S-box derived from GF(2^8) arithmetic.
// Honours INV_SBOX_PIPE_EN for the expected latency.
module tb_inv_sbox_serial;

  localparam int unsigned LANES = 4;
`ifdef INV_SBOX_PIPE_EN
  localparam int unsigned LAT = 16 / LANES + 1;
`else
  localparam int unsigned LAT = 16 / LANES;
`endif

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  logic [7:0]   golden [256];
  int           n_vec = 0;
  int           n_err = 0;
  int           cyc   = 0;

  inv_sbox_serial #(.LANES(LANES)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // Forward S-box from first principles, then inverted into the golden table
  task automatic build_golden();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      golden[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] expect_of(input logic [127:0] d);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = golden[d[8*i +: 8]];
    return r;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Present d, wait for acceptance, then count cycles until out_valid
  task automatic capture_and_wait(input logic [127:0] d, output int lat);
    int n;
    in_data  = d;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check("ready_wait", 128'(in_ready), 128'(1));
    tick();
    in_valid = 1'b0;
    check("busy_run", 128'(busy), 128'(1));
    lat = 0;
    while (!out_valid && lat < int'(LAT) + 10) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_block(input string tag, input logic [127:0] d, input logic [127:0] exp);
    int lat;
    capture_and_wait(d, lat);
    check({tag, "_lat"}, 128'(lat), 128'(LAT));
    check({tag, "_data"}, out_data, exp);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_ovalid_drop"}, 128'(out_valid), 128'(0));
    check({tag, "_iready_back"}, 128'(in_ready), 128'(1));
  endtask

  initial begin
    logic [127:0] d, exp;
    int           lat, prev_cap, n, mid;
    bit           saw_valid;

    build_golden();

    // Reset with in_valid high: nothing may be captured
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_data   = {128{1'b1}};
    out_ready = 1'b0;
    tick();
    tick();
    check("rst_in_ready", 128'(in_ready), 128'(0));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_out_data", out_data, 128'(0));
    rst      = 1'b0;
    in_valid = 1'b0;
    tick();
    check("post_rst_in_ready", 128'(in_ready), 128'(1));
    check("post_rst_busy", 128'(busy), 128'(0));
    check("post_rst_out_data", out_data, 128'(0));

    run_block("all63", {16{8'h63}}, 128'(0));
    run_block("pattern", {4{32'hED160100}}, {4{32'h53FF0952}});

    // Backpressure: result held, input ignored
    d = 128'h0123456789abcdeffedcba9876543210;
    exp = expect_of(d);
    capture_and_wait(d, lat);
    check("bp_lat", 128'(lat), 128'(LAT));
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      in_data  = ~d;
      tick();
      check("bp_out_valid", 128'(out_valid), 128'(1));
      check("bp_out_data", out_data, exp);
      check("bp_in_ready", 128'(in_ready), 128'(0));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_release_valid", 128'(out_valid), 128'(0));
    check("bp_release_busy", 128'(busy), 128'(0));
    check("bp_hold_data", out_data, exp);

    // Reset in the middle of RUN
    mid = (16 / LANES > 2) ? 2 : 0;
    in_data  = 128'hfeedface0badc0de1122334455667788;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check("mid_ready_wait", 128'(in_ready), 128'(1));
    tick();
    in_valid = 1'b0;
    repeat (mid) tick();
    rst = 1'b1;
    tick();
    check("mid_rst_valid", 128'(out_valid), 128'(0));
    check("mid_rst_busy", 128'(busy), 128'(0));
    check("mid_rst_in_ready", 128'(in_ready), 128'(0));
    check("mid_rst_data", out_data, 128'(0));
    rst = 1'b0;
    tick();
    check("mid_post_in_ready", 128'(in_ready), 128'(1));
    saw_valid = 1'b0;
    for (int i = 0; i < int'(LAT) + 2; i++) begin
      tick();
      if (out_valid) saw_valid = 1'b1;
    end
    check("mid_no_pulse", 128'(saw_valid), 128'(0));
    d = 128'h00112233445566778899aabbccddeeff;
    run_block("mid_next", d, expect_of(d));

    // Back-to-back sweep over all 256 byte values
    in_valid  = 1'b1;
    out_ready = 1'b1;
    prev_cap  = 0;
    for (int b = 0; b < 16; b++) begin
      for (int i = 0; i < 16; i++) d[8*i +: 8] = 8'(16 * b + i);
      in_data = d;
      n = 0;
      while (!in_ready && n < 20) begin
        tick();
        n++;
      end
      check("b2b_ready", 128'(in_ready), 128'(1));
      if (b > 0) check("b2b_period", 128'(cyc - prev_cap), 128'(LAT + 2));
      prev_cap = cyc;
      tick();
      lat = 0;
      while (!out_valid && lat < int'(LAT) + 10) begin
        tick();
        lat++;
      end
      check("b2b_lat", 128'(lat), 128'(LAT));
      check("b2b_data", out_data, expect_of(d));
    end
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tick();
    check("end_idle_busy", 128'(busy), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
